mem_access: RTL and testbench

- Memory/write-back stage that consumes the execute stage's alu_out and rs2_data.
- For loads and stores, it treats alu_out as a byte address and runs a request/grant/response transaction with data memory. Load data is aligned and sign- or zero-extended.
- For ALU ops, it forwards alu_out to the register file.
- It stalls the front of the pipeline while a memory transaction is outstanding.

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/type_pkg.sv | 6 +
 rtl/load_align.sv | 28 ++
 rtl/mem_access.sv | 178 +++++++++++++++++
 tb/tb_mem_access.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit types and lane helpers.
// Shared by mem_access and load_align.
package lsu_pkg;
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_t;

    // Illegal size encodings or an address not aligned to the access size.
    function automatic logic is_misaligned(
        input logic       is_load,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic bad_f3;
        logic bad_off;
        if (is_load) begin
            bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end else begin
            bad_f3 = (f3 > 3'b010);
        end
        case (f3[1:0])
            2'b01:   bad_off = off[0];
            2'b10:   bad_off = (off != 2'b00);
            default: bad_off = 1'b0;
        endcase
        return bad_f3 | bad_off;
    endfunction

    // Byte enables for a store of the given size at the given offset.
    function automatic logic [3:0] lane_be(
        input logic [1:0] sz,
        input logic [1:0] off
    );
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] lane_data(
        input logic [1:0]  sz,
        input logic [31:0] rs2
    );
        case (sz)
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction
endpackage

// File: rtl/type_pkg.sv
// Shared datapath types.
// Word-wide data and byte-address types used across pipeline stages.
package type_pkg;
    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;
endpackage

// File: rtl/load_align.sv
// Load data alignment and extension.
// Picks the addressed byte/half out of a read word and extends it.
module load_align
    import type_pkg::*;
    import lsu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    input  data_t      rdata,
    output data_t      data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select, then sign/zero extend by funct3.
    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (funct3)
            LB:      data = {{24{byte_v[7]}}, byte_v};
            LH:      data = {{16{half_v[15]}}, half_v};
            LBU:     data = {24'h0, byte_v};
            LHU:     data = {16'h0, half_v};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory / write-back stage.
// Runs req/gnt/rvalid transactions for loads and stores, forwards ALU results.
module mem_access
    import type_pkg::*;
    import lsu_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_addr,
    input  data_t       alu_out,
    input  data_t       rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output addr_t       dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err
);
    localparam logic [15:0] TMO_LAST =
        16'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    addr_t       addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;
    logic [15:0] cnt_q, cnt_d;
    data_t       ld_data;
    logic        tmo_hit;

    load_align u_align (
        .funct3  (f3_q),
        .addr_lo (off_q),
        .rdata   (dmem_rdata),
        .data    (ld_data)
    );

    assign tmo_hit      = (BUS_TIMEOUT != 0) && (cnt_q == TMO_LAST);
    assign in_ready     = (state_q == IDLE);
    assign stall        = !in_ready;
    assign dmem_req     = (state_q == REQ);
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign wb_en        = wb_en_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

    // Next-state, request capture and one-cycle result pulses.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        off_d     = off_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (mem_read || mem_write) begin
                        if (is_misaligned(mem_read, funct3, alu_out[1:0])) begin
                            mis_d = 1'b1;
                        end else begin
                            addr_d  = {alu_out[31:2], 2'b00};
                            off_d   = alu_out[1:0];
                            we_d    = mem_write;
                            be_d    = lane_be(funct3[1:0], alu_out[1:0]);
                            wdata_d = lane_data(funct3[1:0], rs2_data);
                            f3_d    = funct3;
                            rd_d    = rd_addr;
                            cnt_d   = '0;
                            state_d = REQ;
                        end
                    end else begin
                        wb_en_d   = reg_write;
                        wb_addr_d = rd_addr;
                        wb_data_d = alu_out;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? IDLE : WAIT;
                end else if (tmo_hit) begin
                    berr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = rd_q;
                    wb_data_d = ld_data;
                    state_d   = IDLE;
                end else if (tmo_hit) begin
                    berr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            off_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            off_q     <= off_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access.
// Transaction-level reference model with a per-cycle output comparator.
module tb_mem_access;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] rs2_data = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        misalign_err;
    logic        bus_err;

    mem_access #(.BUS_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .funct3       (funct3),
        .rd_addr      (rd_addr),
        .alu_out      (alu_out),
        .rs2_data     (rs2_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .stall        (stall),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        exp_ready = 1'b1;
    logic        exp_req   = 1'b0;
    logic        exp_we    = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_be    = '0;
    logic        exp_wb    = 1'b0;
    logic [4:0]  exp_wba   = '0;
    logic [31:0] exp_wbd   = '0;
    logic        exp_mis   = 1'b0;
    logic        exp_berr  = 1'b0;

    logic        p_wb   = 1'b0;
    logic [4:0]  p_wba  = '0;
    logic [31:0] p_wbd  = '0;
    logic        p_mis  = 1'b0;
    logic        p_berr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference rules, written from the access-size point of view.
    function automatic bit m_mis(input bit ld, input logic [2:0] f3,
                                 input logic [31:0] a);
        int bytes;
        bit bad;
        bytes = 1 << f3[1:0];
        if (ld) bad = (f3 == 3) || (f3 == 6) || (f3 == 7);
        else    bad = (f3 > 2);
        return bad || ((a % bytes) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3,
                                        input logic [31:0] a);
        int bytes;
        bytes = 1 << f3[1:0];
        return 4'(((1 << bytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] v);
        if (f3[1:0] == 2'd0) return (v & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (v & 32'hFFFF) * 32'h0001_0001;
        return v;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF; if (v > 127) v = v - 256; end
            3'd1: begin v = v & 32'hFFFF; if (v > 32767) v = v - 65536; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    // Per-cycle comparison of every meaningful output.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", 32'(in_ready), 32'd1);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_req", 32'(dmem_req), 32'd0);
            chk("rst_we", 32'(dmem_we), 32'd0);
            chk("rst_addr", dmem_addr, 32'd0);
            chk("rst_be", 32'(dmem_be), 32'd0);
            chk("rst_wb_en", 32'(wb_en), 32'd0);
            chk("rst_wb_data", wb_data, 32'd0);
            chk("rst_mis", 32'(misalign_err), 32'd0);
            chk("rst_berr", 32'(bus_err), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("stall", 32'(stall), 32'(!exp_ready));
            chk("dmem_req", 32'(dmem_req), 32'(exp_req));
            chk("wb_en", 32'(wb_en), 32'(exp_wb));
            chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
            chk("bus_err", 32'(bus_err), 32'(exp_berr));
            if (exp_req) begin
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                if (exp_we) begin
                    chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                    chk("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
            if (exp_wb) begin
                chk("wb_addr", 32'(wb_addr), 32'(exp_wba));
                chk("wb_data", wb_data, exp_wbd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_wb   = p_wb;
        exp_wba  = p_wba;
        exp_wbd  = p_wbd;
        exp_mis  = p_mis;
        exp_berr = p_berr;
        p_wb   = 1'b0;
        p_mis  = 1'b0;
        p_berr = 1'b0;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        dmem_gnt    = 1'($urandom % 2);
        dmem_rvalid = 1'($urandom % 2);
        dmem_rdata  = $urandom;
    endtask

    task automatic garbage();
        in_valid    = 1'($urandom % 2);
        mem_read    = 1'($urandom % 2);
        mem_write   = !mem_read && 1'($urandom % 2);
        reg_write   = 1'($urandom % 2);
        funct3      = 3'($urandom);
        rd_addr     = 5'($urandom);
        alu_out     = $urandom;
        rs2_data    = $urandom;
        dmem_rvalid = 1'($urandom % 2);
        dmem_rdata  = $urandom;
    endtask

    task automatic do_op(input bit ld, input bit st, input bit rw,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] rs2,
                         input int gd, input int rdl,
                         input logic [31:0] rdata);
        in_valid  = 1'b1;
        mem_read  = ld;
        mem_write = st;
        reg_write = rw;
        funct3    = f3;
        rd_addr   = rd;
        alu_out   = a;
        rs2_data  = rs2;
        dmem_gnt  = 1'($urandom % 2);
        if (!ld && !st) begin
            p_wb  = rw;
            p_wba = rd;
            p_wbd = a;
            tick();
            idle_inputs();
            return;
        end
        if (m_mis(ld, f3, a)) begin
            p_mis = 1'b1;
            tick();
            idle_inputs();
            return;
        end
        tick();
        exp_req   = 1'b1;
        exp_ready = 1'b0;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_we    = st;
        exp_be    = m_be(f3, a);
        exp_wdata = m_wdata(f3, rs2);
        for (int i = 0; i < 100; i++) begin
            garbage();
            dmem_gnt = (i == gd);
            if (dmem_gnt) begin
                tick();
                exp_req = 1'b0;
                if (st) begin
                    exp_ready = 1'b1;
                    idle_inputs();
                    return;
                end
                break;
            end
            if (i == TMO - 1) begin
                p_berr = 1'b1;
                tick();
                exp_req   = 1'b0;
                exp_ready = 1'b1;
                idle_inputs();
                return;
            end
            tick();
        end
        dmem_gnt = 1'b0;
        for (int j = 0; j < 100; j++) begin
            garbage();
            dmem_gnt    = 1'($urandom % 2);
            dmem_rvalid = (j == rdl);
            if (dmem_rvalid) begin
                dmem_rdata = rdata;
                p_wb  = 1'b1;
                p_wba = rd;
                p_wbd = m_load(f3, a, rdata);
                tick();
                exp_ready = 1'b1;
                idle_inputs();
                return;
            end
            if (j == TMO - 1) begin
                p_berr = 1'b1;
                tick();
                exp_ready = 1'b1;
                idle_inputs();
                return;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("pin_lb", m_load(3'd0, 32'h102, 32'h0080_0000), 32'hFFFF_FF80);
        chk("pin_lbu", m_load(3'd4, 32'h102, 32'h0080_0000), 32'h0000_0080);
        chk("pin_sb_be", 32'(m_be(3'd0, 32'h103)), 32'h8);
        chk("pin_sb_wd", m_wdata(3'd0, 32'hAABB_CCDD), 32'hDDDD_DDDD);
        chk("pin_sh_be", 32'(m_be(3'd1, 32'h102)), 32'hC);
        chk("pin_lh_mis", 32'(m_mis(1'b1, 3'd1, 32'h101)), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        do_op(0, 0, 1, 3'd0, 5'd5, 32'h0000_1234, 0, 0, 0, 0);
        @(negedge clk);
        chk("alu_wb_en", 32'(wb_en), 32'd1);
        chk("alu_wb_addr", 32'(wb_addr), 32'd5);
        chk("alu_wb_data", wb_data, 32'h1234);

        do_op(0, 1, 0, 3'd0, 5'd0, 32'h103, 32'hAABB_CCDD, 3, 0, 0);
        @(negedge clk);
        chk("sb_done_ready", 32'(in_ready), 32'd1);

        do_op(1, 0, 1, 3'd0, 5'd7, 32'h102, 0, 0, 1, 32'h0080_0000);
        @(negedge clk);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);

        do_op(1, 0, 1, 3'd4, 5'd8, 32'h102, 0, 0, 1, 32'h0080_0000);
        @(negedge clk);
        chk("lbu_wb_data", wb_data, 32'h0000_0080);

        do_op(1, 0, 1, 3'd1, 5'd9, 32'h101, 0, 0, 0, 0);
        @(negedge clk);
        chk("lh_mis_pulse", 32'(misalign_err), 32'd1);
        chk("lh_mis_req", 32'(dmem_req), 32'd0);
        chk("lh_mis_wb", 32'(wb_en), 32'd0);

        do_op(1, 0, 1, 3'd2, 5'd10, 32'h200, 0, 0, 99, 0);
        @(negedge clk);
        chk("tmo_berr", 32'(bus_err), 32'd1);
        chk("tmo_ready", 32'(in_ready), 32'd1);

        do_op(0, 0, 1, 3'd0, 5'd1, 32'h11, 0, 0, 0, 0);
        do_op(0, 0, 1, 3'd0, 5'd2, 32'h22, 0, 0, 0, 0);
        do_op(0, 0, 0, 3'd0, 5'd3, 32'h33, 0, 0, 0, 0);
        tick();

        in_valid  = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        reg_write = 1'b1;
        funct3    = 3'd2;
        rd_addr   = 5'd4;
        alu_out   = 32'h300;
        dmem_gnt  = 1'b0;
        dmem_rvalid = 1'b0;
        tick();
        exp_req   = 1'b1;
        exp_ready = 1'b0;
        exp_addr  = 32'h300;
        exp_we    = 1'b0;
        in_valid  = 1'b0;
        dmem_gnt  = 1'b1;
        tick();
        dmem_gnt  = 1'b0;
        exp_req   = 1'b0;
        #2;
        rst_n     = 1'b0;
        exp_ready = 1'b1;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_wb", 32'(wb_en), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        tick();
        tick();

        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom % 4;
            case (kind)
                0: begin
                    garbage();
                    in_valid = 1'b0;
                    tick();
                end
                1: do_op(0, 0, 1'($urandom % 2), 3'($urandom), 5'($urandom),
                         $urandom, $urandom, 0, 0, 0);
                2: do_op(1, 0, 1, 3'($urandom), 5'($urandom),
                         $urandom, $urandom, $urandom % 6, $urandom % 6,
                         $urandom);
                default: do_op(0, 1, 0, 3'($urandom % 4), 5'($urandom),
                               $urandom, $urandom, $urandom % 6, 0, 0);
            endcase
        end
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
